// File: rtl/conv_cotm_pkg.sv
// Shared definitions for the convolutional clause engine: FSM encodings,
// clause field offsets and the patch-size legality check.
package conv_cotm_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EVAL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Each clause half is {patch, xpos, ypos}, with ypos at bit 0.
    function automatic int y_off();
        return 0;
    endfunction

    function automatic int x_off(input int py_w);
        return py_w;
    endfunction

    function automatic int p_off(input int py_w, input int px_w);
        return py_w + px_w;
    endfunction

    function automatic logic cfg_bad(input logic [2:0] p, input int patch_max);
        return !p[0] || (p < 3'd3) || ({29'd0, p} > 32'(patch_max));
    endfunction

endpackage

// File: rtl/conv_clause_match.sv
// One patch-window matcher: include/negated literal test against a window,
// result registered.
module conv_clause_match #(
    parameter int HALF_W = 107
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [HALF_W-1:0] inc,
    input  logic [HALF_W-1:0] neg,
    input  logic [HALF_W-1:0] lit,
    output logic              match
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else begin
            match <= en & (&(lit | ~inc)) & (&(~lit | ~neg));
        end
    end

endmodule

// File: rtl/conv_clause_engine.sv
// Convolutional clause evaluator: one clause against NUM_PE windows per beat,
// ORs matches into clause_op, counts matches and forwards windows down the chain.
//   state    | meaning
//   ST_IDLE  | waiting for a clause load
//   ST_EVAL  | accepting window beats of one image
//   ST_DRAIN | two cycles letting the last beats reach the accumulators
//   ST_DONE  | result presented until out_ready
module conv_clause_engine
    import conv_cotm_pkg::*;
#(
    parameter int NUM_PE    = 8,
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int PATCH_MAX = 7,
    parameter int CNT_W     = 10,
    localparam int PX_W     = IMG_W - 3,
    localparam int PY_W     = IMG_H - 3,
    localparam int PP_W     = PATCH_MAX * PATCH_MAX,
    localparam int HALF_W   = PY_W + PX_W + PP_W,
    localparam int CLAUSE_W = 2 * HALF_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               patch_size,
    output logic                     cfg_err,
    input  logic                     clause_valid,
    output logic                     clause_ready,
    input  logic [CLAUSE_W-1:0]      clause_data,
    input  logic                     win_valid,
    input  logic                     win_last,
    input  logic [NUM_PE-1:0]        pe_en,
    input  logic [PX_W-1:0]          win_x,
    input  logic [NUM_PE*PY_W-1:0]   win_y,
    input  logic [NUM_PE*PP_W-1:0]   win_patch,
    input  logic                     img_abort,
    input  logic                     prev_op,
    output logic                     fwd_valid,
    output logic                     fwd_last,
    output logic [NUM_PE-1:0]        fwd_pe_en,
    output logic [PX_W-1:0]          fwd_x,
    output logic [NUM_PE*PY_W-1:0]   fwd_y,
    output logic [NUM_PE*PP_W-1:0]   fwd_patch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     clause_op,
    output logic [CNT_W-1:0]         match_cnt
);

    localparam int X_OFF = x_off(PY_W);
    localparam int P_OFF = p_off(PY_W, PX_W);

    logic [1:0]              state;
    logic                    drain_cnt;
    logic [HALF_W-1:0]       inc_q, neg_q, use_mask;
    logic [31:0]             p32;
    logic                    s1_valid, s1_eval, s1_last;
    logic [NUM_PE-1:0]       s1_pe_en;
    logic [PX_W-1:0]         s1_x;
    logic [NUM_PE*PY_W-1:0]  s1_y;
    logic [NUM_PE*PP_W-1:0]  s1_patch;
    logic [NUM_PE-1:0]       match;
    logic [CNT_W:0]          pop, sum;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    op_nxt;

    assign cfg_err      = cfg_bad(patch_size, PATCH_MAX);
    assign clause_ready = (state == ST_IDLE) & ~cfg_err;
    assign out_valid    = (state == ST_DONE);
    assign p32          = {29'd0, patch_size};

    // Literals outside the P x P patch or beyond the valid position range are dropped at load.
    for (genvar b = 0; b < HALF_W; b++) begin : g_mask
        if (b < X_OFF) begin : g_y
            assign use_mask[b] = p32 < 32'(IMG_H - b);
        end else if (b < P_OFF) begin : g_x
            assign use_mask[b] = p32 < 32'(IMG_W - (b - X_OFF));
        end else begin : g_p
            localparam int R  = (b - P_OFF) / PATCH_MAX;
            localparam int C  = (b - P_OFF) % PATCH_MAX;
            localparam int RC = (R > C) ? R : C;
            assign use_mask[b] = p32 > 32'(RC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_eval   <= 1'b0;
            s1_last   <= 1'b0;
            s1_pe_en  <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_patch  <= '0;
            fwd_valid <= 1'b0;
            fwd_last  <= 1'b0;
            fwd_pe_en <= '0;
            fwd_x     <= '0;
            fwd_y     <= '0;
            fwd_patch <= '0;
        end else begin
            s1_valid  <= win_valid & ~img_abort;
            s1_eval   <= win_valid & ~img_abort & (state == ST_EVAL);
            s1_last   <= win_last;
            s1_pe_en  <= pe_en;
            s1_x      <= win_x;
            s1_y      <= win_y;
            s1_patch  <= win_patch;
            fwd_valid <= s1_valid & ~img_abort;
            fwd_last  <= s1_last;
            fwd_pe_en <= s1_pe_en;
            fwd_x     <= s1_x;
            fwd_y     <= s1_y;
            fwd_patch <= s1_patch;
        end
    end

    for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
        logic [HALF_W-1:0] lit;
        assign lit = {s1_patch[i*PP_W +: PP_W], s1_x, s1_y[i*PY_W +: PY_W]};
        conv_clause_match #(.HALF_W(HALF_W)) u_match (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (s1_eval & s1_pe_en[i]),
            .inc   (inc_q),
            .neg   (neg_q),
            .lit   (lit),
            .match (match[i])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            pop = pop + {{CNT_W{1'b0}}, match[i]};
        end
        sum     = {1'b0, match_cnt} + pop;
        cnt_nxt = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        op_nxt  = clause_op | prev_op | (|match);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
            inc_q     <= '0;
            neg_q     <= '0;
            clause_op <= 1'b0;
            match_cnt <= '0;
        end else if (img_abort && state != ST_IDLE) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clause_valid && clause_ready) begin
                        inc_q     <= clause_data[HALF_W-1:0] & use_mask;
                        neg_q     <= clause_data[CLAUSE_W-1:HALF_W] & use_mask;
                        clause_op <= 1'b0;
                        match_cnt <= '0;
                        state     <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    clause_op <= op_nxt;
                    match_cnt <= cnt_nxt;
                    if (win_valid && win_last) begin
                        drain_cnt <= 1'b1;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    clause_op <= op_nxt;
                    match_cnt <= cnt_nxt;
                    if (drain_cnt == 1'b0) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_clause_engine.sv
// Bench for conv_clause_engine: directed and random images against a
// literal-by-literal clause model, plus a forward-path delay checker.
module tb_conv_clause_engine;

    localparam int NUM_PE    = 8;
    localparam int IMG_W     = 32;
    localparam int IMG_H     = 32;
    localparam int PATCH_MAX = 7;
    localparam int CNT_W     = 10;
    localparam int PX_W      = IMG_W - 3;
    localparam int PY_W      = IMG_H - 3;
    localparam int PP_W      = PATCH_MAX * PATCH_MAX;
    localparam int HALF_W    = PY_W + PX_W + PP_W;
    localparam int CLAUSE_W  = 2 * HALF_W;
    localparam int X_OFF     = PY_W;
    localparam int P_OFF     = PY_W + PX_W;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int MAXB      = 140;
    localparam int FWD_W     = 1 + NUM_PE + PX_W + NUM_PE*PY_W + NUM_PE*PP_W;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [2:0]              patch_size;
    logic                    cfg_err;
    logic                    clause_valid;
    logic                    clause_ready;
    logic [CLAUSE_W-1:0]     clause_data;
    logic                    win_valid, win_last;
    logic [NUM_PE-1:0]       pe_en;
    logic [PX_W-1:0]         win_x;
    logic [NUM_PE*PY_W-1:0]  win_y;
    logic [NUM_PE*PP_W-1:0]  win_patch;
    logic                    img_abort, prev_op;
    logic                    fwd_valid, fwd_last;
    logic [NUM_PE-1:0]       fwd_pe_en;
    logic [PX_W-1:0]         fwd_x;
    logic [NUM_PE*PY_W-1:0]  fwd_y;
    logic [NUM_PE*PP_W-1:0]  fwd_patch;
    logic                    out_valid, out_ready, clause_op;
    logic [CNT_W-1:0]        match_cnt;

    int n_cmp, n_mis;

    logic [NUM_PE-1:0]       b_en    [MAXB];
    logic [PX_W-1:0]         b_x     [MAXB];
    logic [NUM_PE*PY_W-1:0]  b_y     [MAXB];
    logic [NUM_PE*PP_W-1:0]  b_patch [MAXB];
    logic                    b_prev  [MAXB];
    logic [HALF_W-1:0]       inc, neg;

    logic             h1_v, h2_v;
    logic [FWD_W-1:0] h1_d, h2_d;

    always #5 clk = ~clk;

    conv_clause_engine #(
        .NUM_PE(NUM_PE), .IMG_W(IMG_W), .IMG_H(IMG_H), .PATCH_MAX(PATCH_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .patch_size(patch_size), .cfg_err(cfg_err),
        .clause_valid(clause_valid), .clause_ready(clause_ready), .clause_data(clause_data),
        .win_valid(win_valid), .win_last(win_last), .pe_en(pe_en), .win_x(win_x),
        .win_y(win_y), .win_patch(win_patch), .img_abort(img_abort), .prev_op(prev_op),
        .fwd_valid(fwd_valid), .fwd_last(fwd_last), .fwd_pe_en(fwd_pe_en), .fwd_x(fwd_x),
        .fwd_y(fwd_y), .fwd_patch(fwd_patch), .out_valid(out_valid), .out_ready(out_ready),
        .clause_op(clause_op), .match_cnt(match_cnt)
    );

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Forward path reference: inputs two edges late, beats dropped by abort.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_v <= 1'b0; h2_v <= 1'b0; h1_d <= '0; h2_d <= '0;
        end else begin
            h1_v <= win_valid & ~img_abort;
            h1_d <= {win_last, pe_en, win_x, win_y, win_patch};
            h2_v <= h1_v & ~img_abort;
            h2_d <= h1_d;
        end
    end

    always @(negedge clk) begin
        chk("fwd_valid", fwd_valid, h2_v);
        if (h2_v) chk("fwd_data", {fwd_last, fwd_pe_en, fwd_x, fwd_y, fwd_patch}, h2_d);
    end

    function automatic logic [HALF_W-1:0] rand_half();
        return HALF_W'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    // Clause truth for one window, walking only the literals that exist for patch edge p.
    function automatic bit model_match(input logic [HALF_W-1:0] ci, input logic [HALF_W-1:0] cn,
                                       input logic [HALF_W-1:0] lit, input int p);
        bit ok = 1'b1;
        int idx;
        for (int r = 0; r < p; r++)
            for (int c = 0; c < p; c++) begin
                idx = P_OFF + r*PATCH_MAX + c;
                if ((ci[idx] && !lit[idx]) || (cn[idx] && lit[idx])) ok = 1'b0;
            end
        for (int k = 0; k < IMG_W - p; k++) begin
            idx = X_OFF + k;
            if ((ci[idx] && !lit[idx]) || (cn[idx] && lit[idx])) ok = 1'b0;
        end
        for (int k = 0; k < IMG_H - p; k++) begin
            if ((ci[k] && !lit[k]) || (cn[k] && lit[k])) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic clear_beats(input int n, input logic [NUM_PE-1:0] en);
        for (int b = 0; b < n; b++) begin
            b_en[b] = en; b_x[b] = '0; b_y[b] = '0; b_patch[b] = '0; b_prev[b] = 1'b0;
        end
    endtask

    task automatic gen_beats(input int n, input logic [HALF_W-1:0] ci, input logic [HALF_W-1:0] cn);
        logic [HALF_W-1:0] lit;
        int fl;
        for (int b = 0; b < n; b++) begin
            b_en[b]   = NUM_PE'($urandom());
            b_prev[b] = 1'b0;
            lit = rand_half();
            if ($urandom_range(3) != 0) lit = (lit & ~cn) | ci;
            b_x[b] = lit[X_OFF +: PX_W];
            for (int pe = 0; pe < NUM_PE; pe++) begin
                lit = rand_half();
                if ($urandom_range(1) == 1) begin
                    lit = (lit & ~cn) | ci;
                    if ($urandom_range(1) == 1) begin
                        fl = $urandom_range(HALF_W-1);
                        lit[fl] = ~lit[fl];
                    end
                end
                b_y[b][pe*PY_W +: PY_W]     = lit[PY_W-1:0];
                b_patch[b][pe*PP_W +: PP_W] = lit[P_OFF +: PP_W];
            end
        end
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!clause_ready && w < 20) begin step(); w++; end
        if (w >= 20) chk({tag, "_ready_timeout"}, 0, 1);
    endtask

    task automatic run_image(input int p, input logic [HALF_W-1:0] ci, input logic [HALF_W-1:0] cn,
                             input int n, input bit gaps, input int hold, input string tag);
        int  exp_cnt, w;
        bit  exp_op;
        logic [HALF_W-1:0] lit;
        wait_ready(tag);
        patch_size   = 3'(p);
        clause_data  = {cn, ci};
        clause_valid = 1'b1;
        // Beat presented while still IDLE must not count.
        win_valid = 1'b1; win_last = 1'b1; pe_en = '1;
        win_x = '0; win_y = '0; win_patch = '0;
        step();
        clause_valid = 1'b0; win_valid = 1'b0; win_last = 1'b0;
        exp_cnt = 0; exp_op = 1'b0;
        for (int b = 0; b < n; b++) begin
            if (gaps && $urandom_range(3) == 0) begin
                win_valid = 1'b0; pe_en = '1; win_x = PX_W'($urandom());
                step();
            end
            win_valid = 1'b1; win_last = (b == n-1);
            pe_en = b_en[b]; win_x = b_x[b]; win_y = b_y[b]; win_patch = b_patch[b];
            prev_op = b_prev[b];
            for (int pe = 0; pe < NUM_PE; pe++) begin
                lit = {b_patch[b][pe*PP_W +: PP_W], b_x[b], b_y[b][pe*PY_W +: PY_W]};
                if (b_en[b][pe] && model_match(ci, cn, lit, p)) exp_cnt++;
            end
            exp_op |= b_prev[b];
            step();
        end
        win_valid = 1'b0; win_last = 1'b0; prev_op = 1'b0;
        if (exp_cnt > 0) exp_op = 1'b1;
        if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
        w = 0;
        while (!out_valid && w < 10) begin step(); w++; end
        chk({tag, "_latency"}, w, 2);
        chk({tag, "_op"}, clause_op, exp_op);
        chk({tag, "_cnt"}, match_cnt, exp_cnt);
        if (hold > 0) begin
            repeat (hold) step();
            chk({tag, "_hold"}, {out_valid, clause_op, match_cnt}, {1'b1, exp_op, CNT_W'(exp_cnt)});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ack"}, {out_valid, clause_ready}, 2'b01);
    endtask

    initial begin
        int p;
        n_cmp = 0; n_mis = 0;
        rst_n = 1'b0; patch_size = 3'd3; clause_valid = 1'b0; clause_data = '0;
        win_valid = 1'b0; win_last = 1'b0; pe_en = '0; win_x = '0; win_y = '0; win_patch = '0;
        img_abort = 1'b0; prev_op = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", clause_ready, 1);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op", clause_op, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_fwd_valid", fwd_valid, 0);

        clear_beats(4, '1);
        b_patch[3][2*PP_W] = 1'b1;
        inc = '0; inc[P_OFF] = 1'b1;
        run_image(3, inc, '0, 4, 1'b0, 0, "p3_px00");

        clear_beats(2, '1);
        run_image(7, '0, '0, 2, 1'b0, 0, "p7_all");
        clear_beats(2, '0);
        run_image(7, '0, '0, 2, 1'b0, 0, "p7_noen");

        inc = '0; inc[27] = 1'b1; inc[X_OFF + 27] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            b_en[b] = NUM_PE'($urandom()); b_prev[b] = 1'b0;
            b_x[b] = PX_W'($urandom());
            b_y[b] = (NUM_PE*PY_W)'({$urandom(), $urandom(), $urandom(), $urandom(),
                                     $urandom(), $urandom(), $urandom(), $urandom()});
            b_patch[b] = '0;
        end
        run_image(5, inc, '0, 3, 1'b0, 0, "p5_pos_unused");
        clear_beats(2, '1);
        inc = '0; inc[26] = 1'b1;
        run_image(5, inc, '0, 2, 1'b0, 0, "p5_pos_edge");
        clear_beats(2, '1);
        inc = '0; inc[P_OFF + 3] = 1'b1;
        run_image(3, inc, '0, 2, 1'b0, 0, "p3_col3");

        clear_beats(3, '0);
        b_prev[1] = 1'b1;
        run_image(3, '0, '0, 3, 1'b0, 0, "prev_op");

        for (int v = 0; v < 8; v++) begin
            patch_size = 3'(v);
            #1;
            chk("cfg_err_sweep", {cfg_err, clause_ready},
                {((v % 2) == 0 || v < 3 || v > PATCH_MAX) ? 2'b10 : 2'b01});
        end
        patch_size = 3'd4; clause_valid = 1'b1;
        repeat (5) step();
        chk("cfg_hold", {cfg_err, clause_ready, out_valid}, 3'b100);
        clause_valid = 1'b0; patch_size = 3'd3;
        #1;
        chk("cfg_still_idle", clause_ready, 1);

        clear_beats(130, '1);
        run_image(3, '0, '0, 130, 1'b0, 10, "saturate");

        for (int t = 0; t < 20; t++) begin
            int n;
            p   = 3 + 2 * int'($urandom_range(2));
            n   = 1 + int'($urandom_range(7));
            inc = rand_half() & rand_half() & rand_half() & rand_half();
            neg = rand_half() & rand_half() & rand_half() & rand_half() & ~inc;
            gen_beats(n, inc, neg);
            if ($urandom_range(4) == 0) b_prev[0] = 1'b1;
            run_image(p, inc, neg, n, 1'b1, int'($urandom_range(3)), "rand");
        end

        wait_ready("abort");
        patch_size = 3'd3; clause_data = '0; clause_valid = 1'b1;
        step();
        clause_valid = 1'b0; win_valid = 1'b1; pe_en = '1;
        step(); step();
        win_valid = 1'b0; img_abort = 1'b1;
        step();
        img_abort = 1'b0;
        chk("abort_idle", {out_valid, clause_ready}, 2'b01);
        win_valid = 1'b1; win_last = 1'b1;
        step();
        win_valid = 1'b0; win_last = 1'b0;
        repeat (4) step();
        chk("abort_no_out", {out_valid, clause_ready}, 2'b01);

        clause_valid = 1'b1;
        step();
        clause_valid = 1'b0; win_valid = 1'b1; win_last = 1'b1;
        step();
        win_valid = 1'b0; win_last = 1'b0;
        step();
        rst_n = 1'b0;
        #2;
        chk("drain_rst", {out_valid, clause_op, match_cnt, fwd_valid, clause_ready},
            {1'b0, 1'b0, CNT_W'(0), 1'b0, 1'b1});
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst", {out_valid, clause_op, match_cnt}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
